// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared definitions for the regfile add sequencer: FSM state encoding and
// default widths used by the interface and the modules.
// No ports (package).
package regfile_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/regfile_add_ctrl_if.sv
// regfile_add_ctrl_if
// Bundles the command handshake, the external write request and the
// register-file ports seen by the add sequencer.
//   cmd_*    : command handshake (front panel -> controller)
//   ext_*    : external write request, wins the write port
//   rf_*     : register file read/write ports
// Modports: master = front panel / register file side, slave = controller.
interface regfile_add_ctrl_if
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src1;
  logic [ADDR_W-1:0] cmd_src2;
  logic [ADDR_W-1:0] cmd_dst;

  logic              ext_wen;
  logic [ADDR_W-1:0] ext_waddr;
  logic [DATA_W-1:0] ext_wdata;

  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output cmd_valid, cmd_src1, cmd_src2, cmd_dst,
    output ext_wen, ext_waddr, ext_wdata,
    output rf_rdata1, rf_rdata2,
    input  cmd_ready,
    input  rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  cmd_valid, cmd_src1, cmd_src2, cmd_dst,
    input  ext_wen, ext_waddr, ext_wdata,
    input  rf_rdata1, rf_rdata2,
    output cmd_ready,
    output rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wport_mux.sv
// regfile_wport_mux
// Priority mux for the single register-file write port. The external writer
// always wins; the controller only gets the port when the external side is
// quiet.
// Ports:
//   ext_wen/ext_waddr/ext_wdata    : external write request (priority)
//   ctrl_wen/ctrl_waddr/ctrl_wdata : controller write request
//   rf_wen/rf_waddr/rf_wdata       : register file write port
module regfile_wport_mux
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ctrl_wen,
  input  logic [ADDR_W-1:0] ctrl_waddr,
  input  logic [DATA_W-1:0] ctrl_wdata,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (ext_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = ext_waddr;
      rf_wdata = ext_wdata;
    end else if (ctrl_wen) begin
      rf_wen   = 1'b1;
      rf_waddr = ctrl_waddr;
      rf_wdata = ctrl_wdata;
    end
  end

endmodule

// File: rtl/regfile_add_ctrl.sv
// regfile_add_ctrl
// Sequencer running "rd <- rs1 + rs2" on a 2-read/1-write register file,
// sharing the write port with an external writer that always has priority.
// Sequence: IDLE -(accept)-> READ -> EXEC -> WRITE -> IDLE; the write and
// the done pulse land three cycles after the accepting edge.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_add_ctrl_if.slave (command, external write, regfile)
//   busy       : an operation is in flight
//   done       : high during the cycle the result is written
//   cout       : carry of the last completed add, held until the next done
//   op_count   : completed operations, wraps
// Build option: define REGFILE_CTRL_SAT_EN to write all-ones when the add
// carries out (unsigned saturation); otherwise the wrapped sum is written.
module regfile_add_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  regfile_add_ctrl_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              cout,
  output logic [CNT_W-1:0]  op_count
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              cout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   sum;
  logic              ctrl_wen;

  // Widened add so the carry comes out as the top bit.
  assign sum = {1'b0, op1_q} + {1'b0, op2_q};

  // The controller's write is held off whenever the external writer is active.
  assign ctrl_wen = (state == ST_WRITE) && !bus.ext_wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            src1_q <= bus.cmd_src1;
            src2_q <= bus.cmd_src2;
            dst_q  <= bus.cmd_dst;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are captured here, so later writes to the sources
          // (including our own write to dst) cannot disturb this add.
          op1_q <= bus.rf_rdata1;
          op2_q <= bus.rf_rdata2;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          carry_q <= sum[DATA_W];
`ifdef REGFILE_CTRL_SAT_EN
          result_q <= sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
          result_q <= sum[DATA_W-1:0];
`endif
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!bus.ext_wen) begin
            cout_q <= carry_q;
            cnt_q  <= cnt_q + CNT_W'(1);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rf_raddr1 = src1_q;
  assign bus.rf_raddr2 = src2_q;
  assign busy          = (state != ST_IDLE);
  assign done          = ctrl_wen;
  assign cout          = cout_q;
  assign op_count      = cnt_q;

  regfile_wport_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wport_mux (
    .ext_wen    (bus.ext_wen),
    .ext_waddr  (bus.ext_waddr),
    .ext_wdata  (bus.ext_wdata),
    .ctrl_wen   (ctrl_wen),
    .ctrl_waddr (dst_q),
    .ctrl_wdata (result_q),
    .rf_wen     (bus.rf_wen),
    .rf_waddr   (bus.rf_waddr),
    .rf_wdata   (bus.rf_wdata)
  );

endmodule

// File: tb/tb_regfile_add_ctrl.sv
// tb_regfile_add_ctrl
// Testbench for regfile_add_ctrl: a behavioural register file sits on the
// rf_* ports, a vector table drives add commands, and a scoreboard queue
// holds the expected writes that are matched against each done pulse.
// The counter is built 4 bits wide so the wrap is reached quickly.
module tb_regfile_add_ctrl;
  import regfile_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic done;
  logic cout;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  regfile_add_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_add_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .cout     (cout),
    .op_count (op_count)
  );

  // Behavioural register file: combinational reads, write on the clock edge.
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) if (bus.rf_wen) mem[bus.rf_waddr] <= bus.rf_wdata;
  assign bus.rf_rdata1 = mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = mem[bus.rf_raddr2];

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic          carry;
    int            exp_cyc;
  } exp_t;

  typedef struct {
    bit            preload;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_data;
    logic          exp_carry;
  } vec_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_op_count = '0;
  bit cout_pending = 1'b0;
  logic cout_exp = 1'b0;

`ifdef REGFILE_CTRL_SAT_EN
  localparam logic [DW-1:0] OVF_FFFF_2 = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] OVF_8_8    = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] OVF_FFFF_1 = 32'hFFFF_FFFF;
`else
  localparam logic [DW-1:0] OVF_FFFF_2 = 32'h0000_0001;
  localparam logic [DW-1:0] OVF_8_8    = 32'h0000_0000;
  localparam logic [DW-1:0] OVF_FFFF_1 = 32'h0000_0000;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each done pulse must match the oldest expected write;
  // cout and op_count are checked one cycle later, once they have updated.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      exp_op_count = '0;
      cout_pending = 1'b0;
    end else begin
      if (cout_pending) begin
        checkOutput("cout", cout, cout_exp);
        checkOutput("op_count", op_count, exp_op_count);
        cout_pending = 1'b0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cycle_cnt);
        end else begin
          e = sb_q.pop_front();
          checkOutput("wr_en", bus.rf_wen, 1'b1);
          checkOutput("wr_addr", bus.rf_waddr, e.dst);
          checkOutput("wr_data", bus.rf_wdata, e.data);
          if (e.exp_cyc >= 0) checkOutput("latency_cycle", cycle_cnt, e.exp_cyc);
          cout_exp     = e.carry;
          cout_pending = 1'b1;
          exp_op_count = exp_op_count + CW'(1);
        end
      end
    end
  end

  task automatic extWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.ext_wen   = 1'b1;
    bus.ext_waddr = addr;
    bus.ext_wdata = data;
    @(negedge clk);
    bus.ext_wen   = 1'b0;
  endtask

  // Presents a command until accepted; optionally queues the expected write
  // due "lat" cycles after the accepting negedge.
  task automatic applyStimulus(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                               input logic [AW-1:0] d, input logic [DW-1:0] exp_data,
                               input logic exp_carry, input int lat, input bit push,
                               output int acc_cyc);
    exp_t e;
    int   waited = 0;
    bit   ok = 1'b0;
    acc_cyc = -1;
    while (!ok && waited < 50) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_src1  = s1;
      bus.cmd_src2  = s2;
      bus.cmd_dst   = d;
      if (bus.cmd_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
      bus.cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cycle_cnt;
    if (push) begin
      e.dst     = d;
      e.data    = exp_data;
      e.carry   = exp_carry;
      e.exp_cyc = cycle_cnt + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < 40) begin
      @(negedge clk);
      #2;
      idle = !busy && (sb_q.size() == 0) && !cout_pending;
      n++;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int acc;
    int accepts;
    int last;
    int guard;
    logic [AW-1:0] stall_addr[3];
    logic [DW-1:0] stall_data[3];
    exp_t e;

    vecs[0] = '{1'b1, 5'd1,  5'd2,  5'd3,  32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{1'b1, 5'd1,  5'd2,  5'd4,  32'hFFFF_FFFF,  32'd2,          OVF_FFFF_2,     1'b1};
    vecs[2] = '{1'b0, 5'd3,  5'd3,  5'd3,  32'd0,          32'd0,          32'd24,         1'b0};
    vecs[3] = '{1'b1, 5'd5,  5'd6,  5'd7,  32'h8000_0000,  32'h8000_0000,  OVF_8_8,        1'b1};
    vecs[4] = '{1'b1, 5'd10, 5'd11, 5'd12, 32'hAAAA_AAAA,  32'h5555_5555,  32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b1, 5'd8,  5'd9,  5'd8,  32'hFFFF_FFFF,  32'd1,          OVF_FFFF_1,     1'b1};

    bus.cmd_valid = 1'b0;
    bus.cmd_src1  = '0;
    bus.cmd_src2  = '0;
    bus.cmd_dst   = '0;
    bus.ext_wen   = 1'b0;
    bus.ext_waddr = '0;
    bus.ext_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_cout", cout, 1'b0);
    checkOutput("rst_op_count", op_count, '0);
    checkOutput("rst_raddr1", bus.rf_raddr1, '0);
    checkOutput("rst_raddr2", bus.rf_raddr2, '0);
    checkOutput("rst_rf_wen", bus.rf_wen, 1'b0);

    // Table-driven adds, including read-modify-write and carry-out cases.
    for (int i = 0; i < 6; i++) begin
      waitIdle();
      if (vecs[i].preload) begin
        extWrite(vecs[i].s1, vecs[i].a);
        extWrite(vecs[i].s2, vecs[i].b);
      end
      applyStimulus(vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].exp_data,
                    vecs[i].exp_carry, 3, 1'b1, acc);
    end
    waitIdle();
    checkOutput("mem_r3", mem[3], 32'd24);
    checkOutput("mem_r4", mem[4], OVF_FFFF_2);

    // External writer holds the port for three WRITE cycles, hitting a
    // source register; the controller's result must follow unchanged.
    stall_addr[0] = 5'd1;  stall_data[0] = 32'hDEAD_0001;
    stall_addr[1] = 5'd20; stall_data[1] = 32'h0000_BEEF;
    stall_addr[2] = 5'd2;  stall_data[2] = 32'h1234_5678;
    extWrite(5'd1, 32'd100);
    extWrite(5'd2, 32'd23);
    applyStimulus(5'd1, 5'd2, 5'd25, 32'd123, 1'b0, 6, 1'b1, acc);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.ext_wen   = 1'b1;
      bus.ext_waddr = stall_addr[j];
      bus.ext_wdata = stall_data[j];
      #2;
      checkOutput("stall_wen", bus.rf_wen, 1'b1);
      checkOutput("stall_waddr", bus.rf_waddr, stall_addr[j]);
      checkOutput("stall_wdata", bus.rf_wdata, stall_data[j]);
      checkOutput("stall_no_done", done, 1'b0);
    end
    @(negedge clk);
    bus.ext_wen = 1'b0;
    waitIdle();
    checkOutput("mem_r25", mem[25], 32'd123);
    checkOutput("mem_r1_ext", mem[1], 32'hDEAD_0001);
    checkOutput("mem_r20_ext", mem[20], 32'h0000_BEEF);
    checkOutput("mem_r2_ext", mem[2], 32'h1234_5678);

    // Reset in EXEC aborts the operation without a write.
    applyStimulus(5'd1, 5'd2, 5'd26, '0, 1'b0, 0, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("abort_rf_wen", bus.rf_wen, 1'b0);
    checkOutput("abort_cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_op_count", op_count, '0);
    checkOutput("abort_cout", cout, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #2;
      checkOutput("abort_quiet_wen", bus.rf_wen, 1'b0);
    end

    // cmd_valid held high: one accept every 4 cycles, counter wraps 15 -> 0.
    extWrite(5'd13, 32'd1);
    extWrite(5'd14, 32'd2);
    accepts = 0;
    last    = -1;
    guard   = 0;
    bus.cmd_src1 = 5'd13;
    bus.cmd_src2 = 5'd14;
    bus.cmd_dst  = 5'd15;
    while (accepts < 17 && guard < 300) begin
      @(negedge clk);
      guard++;
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) begin
        if (last >= 0) checkOutput("accept_spacing", cycle_cnt - last, 4);
        last      = cycle_cnt;
        e.dst     = 5'd15;
        e.data    = 32'd3;
        e.carry   = 1'b0;
        e.exp_cyc = cycle_cnt + 3;
        sb_q.push_back(e);
        accepts++;
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (accepts < 17) begin
      checks++;
      errors++;
      $display("[TB] FAIL stream_accepts actual=%0d expected=17", accepts);
    end
    waitIdle();
    checkOutput("op_count_wrap", op_count, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
